pwm_duty_decoder: RTL and testbench



---
 rtl/pwm_duty_decoder_pkg.sv | 15 +
 rtl/pwm_duty_decoder_in_filter.sv | 59 +++++
 rtl/pwm_duty_decoder.sv | 195 +++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared types and constants for the PWM duty decoder.
package pwm_duty_decoder_pkg;

  localparam int unsigned DEFAULT_CNT_W = 16;
  localparam int unsigned DUTY_STEPS    = 10;
  localparam int unsigned DUTY_W        = 4;
  localparam int unsigned FILT_CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_duty_decoder_in_filter.sv
// Input conditioning: 2-flop synchronizer, FILT_LEN-sample glitch filter and
// edge detect on the filtered level.
module pwm_in_filter
  import pwm_duty_decoder_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_level;
  logic                  r_rise;
  logic                  r_fall;
  logic [FILT_CNT_W-1:0] r_cnt;
  logic [FILT_CNT_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + FILT_CNT_W'(1);

  // Level flips only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (w_cnt_nxt == FILT_CNT_W'(FILT_LEN)) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_nxt;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receiver: measures period and high time of a filtered PWM input and
// reports duty in tenths via a repeated-subtraction divider.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int unsigned CNT_W    = DEFAULT_CNT_W,
  parameter int unsigned FILT_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              ena,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              stuck
);

  localparam int unsigned      REM_W   = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_level;
  logic              w_rise;
  logic              w_fall;
  logic              w_close;
  logic              w_timeout;
  logic              w_overflow;
  logic              w_start;
  logic              w_rem_ge;
  logic [CNT_W:0]    w_sum;

  state_t            r_state;
  logic [CNT_W-1:0]  r_hi_cnt;
  logic [CNT_W-1:0]  r_lo_cnt;
  logic              r_div_busy;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div_p;
  logic [CNT_W-1:0]  r_div_h;
  logic [DUTY_W-1:0] r_div_q;
  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high_time;
  logic              r_valid;
  logic              r_stuck;

  pwm_in_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_sum      = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
  assign w_overflow = w_sum[CNT_W];
  assign w_start    = w_close && !w_overflow && !r_div_busy;
  assign w_rem_ge   = (r_rem >= REM_W'(r_div_p));

  // Period-closing edge and counter-saturation detection.
  always_comb begin
    w_close   = 1'b0;
    w_timeout = 1'b0;
    if (ena) begin
      unique case (r_state)
        ST_HIGH: w_timeout = !w_fall && (r_hi_cnt == CNT_MAX);
        ST_LOW: begin
          w_close   = w_rise;
          w_timeout = !w_rise && (r_lo_cnt == CNT_MAX);
        end
        default: ;
      endcase
    end
  end

  // Measurement FSM and high/low counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else if (!ena) begin
      r_state  <= ST_IDLE;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_hi_cnt <= '0;
          r_lo_cnt <= '0;
          if (w_rise) begin
            r_state  <= ST_HIGH;
            r_hi_cnt <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_state  <= ST_LOW;
            r_lo_cnt <= CNT_W'(1);
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
          end else begin
            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (w_close) begin
            r_lo_cnt <= '0;
            if (w_overflow) begin
              r_state  <= ST_IDLE;
              r_hi_cnt <= '0;
            end else begin
              r_state  <= ST_HIGH;
              r_hi_cnt <= CNT_W'(1);
            end
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
          end else begin
            r_lo_cnt <= r_lo_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hi_cnt <= '0;
          r_lo_cnt <= '0;
        end
      endcase
    end
  end

  // Divider and result registers; a snapshot arriving while busy is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_busy  <= 1'b0;
      r_rem       <= '0;
      r_div_p     <= '0;
      r_div_h     <= '0;
      r_div_q     <= '0;
      r_duty      <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!ena) begin
        r_div_busy <= 1'b0;
      end else if (w_timeout) begin
        r_div_busy  <= 1'b0;
        r_stuck     <= 1'b1;
        r_duty      <= w_level ? DUTY_W'(DUTY_STEPS) : '0;
        r_period    <= '0;
        r_high_time <= '0;
        r_valid     <= 1'b1;
      end else begin
        if (w_rise || w_fall) begin
          r_stuck <= 1'b0;
        end
        if (r_div_busy) begin
          if (w_rem_ge) begin
            r_rem   <= r_rem - REM_W'(r_div_p);
            r_div_q <= r_div_q + DUTY_W'(1);
          end else begin
            r_div_busy  <= 1'b0;
            r_duty      <= r_div_q;
            r_period    <= r_div_p;
            r_high_time <= r_div_h;
            r_valid     <= 1'b1;
          end
        end
        if (w_start) begin
          r_div_busy <= 1'b1;
          r_div_p    <= w_sum[CNT_W-1:0];
          r_div_h    <= r_hi_cnt;
          r_rem      <= REM_W'(r_hi_cnt) * REM_W'(DUTY_STEPS);
          r_div_q    <= '0;
        end
      end
    end
  end

  assign duty      = r_duty;
  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign stuck     = r_stuck;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized and directed bench for pwm_duty_decoder, checked against
// duty = floor(10*high/period) computed directly from the drive waveform.
module tb_pwm_duty_decoder;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic             ena;
  logic [3:0]       duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;

  typedef struct {
    int p;
    int h;
    int d;
  } meas_t;

  meas_t q_meas[$];
  int    total = 0;
  int    bad   = 0;

  pwm_duty_decoder #(
    .CNT_W    (CNT_W),
    .FILT_LEN (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .ena       (ena),
    .duty      (duty),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    meas_t m;
    if (valid === 1'b1) begin
      m.p = int'(period);
      m.h = int'(high_time);
      m.d = int'(duty);
      q_meas.push_back(m);
    end
  end

  function automatic int exp_duty(input int h, input int p);
    return (10 * h) / p;
  endfunction

  task automatic drive_wave(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic settle();
    pwm_in = 1'b0;
    ena    = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    q_meas.delete();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    ena    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (duty !== 4'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", duty); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    total++; if (high_time !== 8'd0) begin bad++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck got=%0b exp=0", stuck); end
  endtask

  task automatic test_loopback();
    settle();
    drive_wave(5, 5, 8);
    repeat (20) @(negedge clk);
    total++;
    if (q_meas.size() < 2) begin bad++; $display("FAIL loop_count got=%0d exp>=2", q_meas.size()); end
    for (int i = 1; i < q_meas.size(); i++) begin
      total++; if (q_meas[i].p != 10) begin bad++; $display("FAIL loop_period got=%0d exp=10", q_meas[i].p); end
      total++; if (q_meas[i].h != 5) begin bad++; $display("FAIL loop_high got=%0d exp=5", q_meas[i].h); end
      total++; if (q_meas[i].d != 5) begin bad++; $display("FAIL loop_duty got=%0d exp=5", q_meas[i].d); end
    end
  endtask

  task automatic run_case(input int h, input int l, input int n);
    settle();
    drive_wave(h, l, n);
    repeat (20) @(negedge clk);
    total++;
    if (q_meas.size() < 1) begin bad++; $display("FAIL case_count h=%0d l=%0d got=0 exp>=1", h, l); end
    foreach (q_meas[i]) begin
      total++;
      if (q_meas[i].p != h + l) begin bad++; $display("FAIL case_period got=%0d exp=%0d", q_meas[i].p, h + l); end
      total++;
      if (q_meas[i].h != h) begin bad++; $display("FAIL case_high got=%0d exp=%0d", q_meas[i].h, h); end
      total++;
      if (q_meas[i].d != exp_duty(h, h + l)) begin
        bad++; $display("FAIL case_duty h=%0d p=%0d got=%0d exp=%0d", h, h + l, q_meas[i].d, exp_duty(h, h + l));
      end
    end
  endtask

  task automatic test_sweep();
    for (int h = 2; h <= 8; h++) run_case(h, 10 - h, 4);
    run_case(37, 63, 3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_case(int'($urandom_range(3, 60)), int'($urandom_range(3, 60)), 4);
    end
  endtask

  task automatic test_glitch();
    settle();
    for (int k = 0; k < 6; k++) begin
      pwm_in = 1'b1; repeat (8) @(negedge clk);
      pwm_in = 1'b0; repeat (5) @(negedge clk);
      pwm_in = 1'b1; @(negedge clk);
      pwm_in = 1'b0; repeat (6) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    total++;
    if (q_meas.size() != 5) begin bad++; $display("FAIL glitch_count got=%0d exp=5", q_meas.size()); end
    foreach (q_meas[i]) begin
      total++; if (q_meas[i].p != 20) begin bad++; $display("FAIL glitch_period got=%0d exp=20", q_meas[i].p); end
      total++; if (q_meas[i].d != 4) begin bad++; $display("FAIL glitch_duty got=%0d exp=4", q_meas[i].d); end
    end
  endtask

  task automatic test_stuck();
    settle();
    pwm_in = 1'b1;
    repeat (270) @(negedge clk);
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_set got=%0b exp=1", stuck); end
    total++; if (duty !== 4'd10) begin bad++; $display("FAIL stuck_duty got=%0d exp=10", duty); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL stuck_period got=%0d exp=0", period); end
    total++; if (high_time !== 8'd0) begin bad++; $display("FAIL stuck_high got=%0d exp=0", high_time); end
    total++;
    if (q_meas.size() != 1) begin bad++; $display("FAIL stuck_valid_count got=%0d exp=1", q_meas.size()); end
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL stuck_clear got=%0b exp=0", stuck); end
    total++; if (q_meas.size() != 1) begin bad++; $display("FAIL stuck_extra_valid got=%0d exp=1", q_meas.size()); end
  endtask

  task automatic test_back_to_back();
    settle();
    drive_wave(2, 2, 20);
    repeat (20) @(negedge clk);
    total++;
    if (q_meas.size() < 1 || q_meas.size() > 18) begin
      bad++; $display("FAIL b2b_count got=%0d exp=1..18", q_meas.size());
    end
    foreach (q_meas[i]) begin
      total++; if (q_meas[i].p != 4) begin bad++; $display("FAIL b2b_period got=%0d exp=4", q_meas[i].p); end
      total++; if (q_meas[i].h != 2) begin bad++; $display("FAIL b2b_high got=%0d exp=2", q_meas[i].h); end
      total++; if (q_meas[i].d != 5) begin bad++; $display("FAIL b2b_duty got=%0d exp=5", q_meas[i].d); end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (duty !== 4'd0) begin bad++; $display("FAIL rmid_duty got=%0d exp=0", duty); end
    total++; if (period !== 8'd0) begin bad++; $display("FAIL rmid_period got=%0d exp=0", period); end
    total++; if (high_time !== 8'd0) begin bad++; $display("FAIL rmid_high got=%0d exp=0", high_time); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", valid); end
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    q_meas.delete();
    drive_wave(6, 18, 1);
    total++;
    if (q_meas.size() != 0) begin bad++; $display("FAIL rmid_early_valid got=%0d exp=0", q_meas.size()); end
    drive_wave(6, 6, 2);
    repeat (20) @(negedge clk);
    total++;
    if (q_meas.size() < 1) begin
      bad++; $display("FAIL rmid_count got=0 exp>=1");
    end else begin
      total++; if (q_meas[0].p != 24) begin bad++; $display("FAIL rmid_period1 got=%0d exp=24", q_meas[0].p); end
      total++; if (q_meas[0].h != 6) begin bad++; $display("FAIL rmid_high1 got=%0d exp=6", q_meas[0].h); end
      total++;
      if (q_meas[0].d != exp_duty(6, 24)) begin
        bad++; $display("FAIL rmid_duty1 got=%0d exp=%0d", q_meas[0].d, exp_duty(6, 24));
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_sweep();
    test_random();
    test_glitch();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
